// File: rtl/sd_data_rx_if.sv
// Bus bundle between the SD DAT receiver and its bus master / sector consumer.
// The master side drives strobes and DAT; the slave side returns bytes and status.
interface sd_data_rx_if;
    logic       sample_en;
    logic [3:0] dat_in;
    logic       start;
    logic       abort;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       busy;
    logic       done;
    logic       crc_err;
    logic       end_err;
    logic       timeout;

    modport master (
        output sample_en, dat_in, start, abort,
        input  byte_data, byte_valid, busy, done,
        input  crc_err, end_err, timeout
    );

    modport slave (
        input  sample_en, dat_in, start, abort,
        output byte_data, byte_valid, busy, done,
        output crc_err, end_err, timeout
    );
endinterface

// File: rtl/sd_data_rx.sv
// SD 4-bit read-data block receiver: start-bit hunt, nibble-to-byte
// assembly, per-line CRC16 check, end-bit check and Nac timeout.
module sd_data_rx #(
    parameter int BLOCK_BYTES     = 512,
    parameter int TIMEOUT_STROBES = 100000
) (
    input logic         clk,
    input logic         reset,
    sd_data_rx_if.slave bus
);
    localparam int NIBS = 2 * BLOCK_BYTES;
    localparam int NW   = $clog2(NIBS) + 1;
    localparam int TW   = $clog2(TIMEOUT_STROBES + 1);
    localparam logic [NW-1:0] LAST_NIB = NW'(NIBS - 1);
    localparam logic [TW-1:0] TO_CNT   = TW'(TIMEOUT_STROBES);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_DATA, S_CRC, S_END, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [NW-1:0]     nib_q, nib_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [3:0]        bit_q, bit_d;
    logic [3:0][15:0]  crc_q, crc_d;
    logic [3:0]        hi_q, hi_d;
    logic [7:0]        byte_q, byte_d;
    logic              bvalid_q, bvalid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              crc_err_q, crc_err_d;
    logic              end_err_q, end_err_d;
    logic              tmo_flag_q, tmo_flag_d;

    function automatic logic [15:0] crc16_step(logic [15:0] c, logic b);
        return {c[14:0], 1'b0} ^ ({16{c[15] ^ b}} & 16'h1021);
    endfunction

    always_comb begin
        state_d    = state_q;
        nib_d      = nib_q;
        tmo_d      = tmo_q;
        bit_d      = bit_q;
        crc_d      = crc_q;
        hi_d       = hi_q;
        byte_d     = byte_q;
        bvalid_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        crc_err_d  = crc_err_q;
        end_err_d  = end_err_q;
        tmo_flag_d = tmo_flag_q;
        if (bus.abort) begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            crc_err_d  = 1'b0;
            end_err_d  = 1'b0;
            tmo_flag_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d    = S_WAIT;
                        busy_d     = 1'b1;
                        crc_err_d  = 1'b0;
                        end_err_d  = 1'b0;
                        tmo_flag_d = 1'b0;
                        crc_d      = '0;
                        nib_d      = '0;
                        tmo_d      = '0;
                        bit_d      = '0;
                    end
                end
                S_WAIT: begin
                    if (bus.sample_en) begin
                        if (bus.dat_in == 4'h0) begin
                            state_d = S_DATA;
                        end else begin
                            tmo_d = tmo_q + 1'b1;
                            if (tmo_d == TO_CNT) begin
                                state_d    = S_DONE;
                                tmo_flag_d = 1'b1;
                                done_d     = 1'b1;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (bus.sample_en) begin
                        for (int i = 0; i < 4; i++)
                            crc_d[i] = crc16_step(crc_q[i], bus.dat_in[i]);
                        // Even nibble is the high half of the byte
                        if (!nib_q[0]) begin
                            hi_d = bus.dat_in;
                        end else begin
                            byte_d   = {hi_q, bus.dat_in};
                            bvalid_d = 1'b1;
                        end
                        nib_d = nib_q + 1'b1;
                        if (nib_q == LAST_NIB)
                            state_d = S_CRC;
                    end
                end
                S_CRC: begin
                    if (bus.sample_en) begin
                        for (int i = 0; i < 4; i++) begin
                            if (bus.dat_in[i] != crc_q[i][15])
                                crc_err_d = 1'b1;
                            crc_d[i] = {crc_q[i][14:0], 1'b0};
                        end
                        bit_d = bit_q + 4'd1;
                        if (bit_q == 4'd15)
                            state_d = S_END;
                    end
                end
                S_END: begin
                    if (bus.sample_en) begin
                        if (bus.dat_in != 4'hF)
                            end_err_d = 1'b1;
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            nib_q      <= '0;
            tmo_q      <= '0;
            bit_q      <= '0;
            crc_q      <= '0;
            hi_q       <= '0;
            byte_q     <= '0;
            bvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            crc_err_q  <= 1'b0;
            end_err_q  <= 1'b0;
            tmo_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            nib_q      <= nib_d;
            tmo_q      <= tmo_d;
            bit_q      <= bit_d;
            crc_q      <= crc_d;
            hi_q       <= hi_d;
            byte_q     <= byte_d;
            bvalid_q   <= bvalid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            crc_err_q  <= crc_err_d;
            end_err_q  <= end_err_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign bus.byte_data  = byte_q;
    assign bus.byte_valid = bvalid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.crc_err    = crc_err_q;
    assign bus.end_err    = end_err_q;
    assign bus.timeout    = tmo_flag_q;
endmodule

// File: tb/tb_sd_data_rx.sv
// Directed bench for sd_data_rx: clean, bad-CRC, bad-end, timeout,
// abort, strobe spacing and mid-block reset.
module tb_sd_data_rx;
    logic clk = 1'b0;
    logic reset;
    int   n_run  = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    logic [7:0] got[$];

    sd_data_rx_if ifc ();

    sd_data_rx #(
        .BLOCK_BYTES    (512),
        .TIMEOUT_STROBES(100)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifc.byte_valid) got.push_back(ifc.byte_data);
        if (ifc.done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_upd(logic [15:0] c, logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    task automatic strobe(input logic [3:0] d, input int gap);
        ifc.sample_en = 1'b1;
        ifc.dat_in    = d;
        @(negedge clk);
        ifc.sample_en = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_start();
        ifc.start = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
    endtask

    task automatic run_block(input string tag, input bit ramp,
                             input int gap, input bit flip,
                             input logic [3:0] endn,
                             input bit exp_crc, input bit exp_end);
        logic [15:0] crc [4];
        logic [7:0]  b;
        logic [3:0]  nib;
        int          base;
        int          bad;
        for (int i = 0; i < 4; i++) crc[i] = 16'h0000;
        got.delete();
        base = done_cnt;
        pulse_start();
        check({tag, "_busy_up"}, ifc.busy, 1);
        repeat (5) strobe(4'hF, gap);
        strobe(4'h0, gap);
        for (int n = 0; n < 512; n++) begin
            b = ramp ? n[7:0] : 8'h00;
            for (int h = 0; h < 2; h++) begin
                nib = (h == 0) ? b[7:4] : b[3:0];
                for (int i = 0; i < 4; i++)
                    crc[i] = crc_upd(crc[i], nib[i]);
                strobe(nib, gap);
            end
        end
        for (int k = 15; k >= 0; k--) begin
            for (int i = 0; i < 4; i++) nib[i] = crc[i][k];
            if (flip && k == 3) nib[2] = ~nib[2];
            strobe(nib, gap);
        end
        strobe(endn, 0);
        check({tag, "_done"}, ifc.done, 1);
        check({tag, "_flags"},
              {ifc.crc_err, ifc.end_err, ifc.timeout},
              {exp_crc, exp_end, 1'b0});
        @(negedge clk);
        check({tag, "_done_pulse"}, ifc.done, 0);
        check({tag, "_busy_down"}, ifc.busy, 0);
        check({tag, "_flags_hold"},
              {ifc.crc_err, ifc.end_err, ifc.timeout},
              {exp_crc, exp_end, 1'b0});
        check({tag, "_nbytes"}, got.size(), 512);
        bad = 0;
        foreach (got[n]) begin
            b = ramp ? n[7:0] : 8'h00;
            if (got[n] !== b) bad++;
        end
        check({tag, "_bytes"}, bad, 0);
        check({tag, "_ndone"}, done_cnt - base, 1);
    endtask

    initial begin
        int base;
        logic [7:0] b;
        reset = 1'b1;
        ifc.sample_en = 1'b0;
        ifc.dat_in    = 4'hF;
        ifc.start     = 1'b0;
        ifc.abort     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs",
              {ifc.byte_data, ifc.byte_valid, ifc.busy, ifc.done,
               ifc.crc_err, ifc.end_err, ifc.timeout}, 0);
        reset = 1'b0;
        @(negedge clk);

        run_block("zero", 0, 0, 0, 4'hF, 0, 0);
        run_block("ramp", 1, 0, 0, 4'hF, 0, 0);
        run_block("crcflip", 1, 0, 1, 4'hF, 1, 0);
        run_block("badend", 1, 0, 0, 4'hE, 0, 1);

        // timeout: 100 non-start strobes
        got.delete();
        base = done_cnt;
        pulse_start();
        repeat (99) strobe(4'hF, 0);
        check("tmo_early", ifc.done, 0);
        strobe(4'hF, 0);
        check("tmo_done", ifc.done, 1);
        check("tmo_flags", {ifc.crc_err, ifc.end_err, ifc.timeout}, 3'b001);
        @(negedge clk);
        check("tmo_busy", ifc.busy, 0);
        check("tmo_nbytes", got.size(), 0);
        check("tmo_ndone", done_cnt - base, 1);

        // abort after 200 bytes
        got.delete();
        base = done_cnt;
        pulse_start();
        strobe(4'hF, 0);
        strobe(4'h0, 0);
        for (int n = 0; n < 200; n++) begin
            b = n[7:0];
            strobe(b[7:4], 0);
            strobe(b[3:0], 0);
        end
        @(negedge clk);
        check("abort_pre_nbytes", got.size(), 200);
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.abort = 1'b0;
        check("abort_busy", ifc.busy, 0);
        for (int n = 200; n < 220; n++) begin
            b = n[7:0];
            strobe(b[7:4], 0);
            strobe(b[3:0], 0);
        end
        @(negedge clk);
        check("abort_nbytes", got.size(), 200);
        check("abort_ndone", done_cnt - base, 0);
        check("abort_flags", {ifc.crc_err, ifc.end_err, ifc.timeout}, 0);
        run_block("post_abort", 1, 0, 0, 4'hF, 0, 0);

        run_block("slow", 1, 3, 0, 4'hF, 0, 0);

        // reset in the middle of a block
        pulse_start();
        strobe(4'hF, 0);
        strobe(4'h0, 0);
        for (int n = 0; n < 25; n++) begin
            b = n[7:0] + 8'h30;
            strobe(b[7:4], 0);
            strobe(b[3:0], 0);
        end
        check("mid_pre_busy", ifc.busy, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_reset_outs",
              {ifc.byte_data, ifc.byte_valid, ifc.busy, ifc.done,
               ifc.crc_err, ifc.end_err, ifc.timeout}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mid_idle_busy", ifc.busy, 0);
        pulse_start();
        check("mid_restart_busy", ifc.busy, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
